// File: rtl/pipe_skid_stage_if.sv
// pipe_skid_stage_if: valid/ready/data handshake channel between pipeline stages.
interface pipe_skid_stage_if #(parameter int DATA_W = 32);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  modport master (output valid, data, input ready);
  modport slave  (input valid, data, output ready);
endinterface

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: handshaked decode/execute register with optional skid entry, flush/stall and bubble counter.
module pipe_skid_stage #(
  parameter int DATA_W = 32,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  pipe_skid_stage_if.slave   up,
  pipe_skid_stage_if.master  dn,
  input  logic               flush,
  input  logic               stall,
  output logic [1:0]         occupancy,
  output logic [CNT_W-1:0]   bubble_cnt,
  input  logic               bubble_clr
);
  logic              rdy, hV, sV, accept, fire;
  logic [DATA_W-1:0] hData, sData;
  // rdy holds in_ready low until the first edge after reset release
  assign up.ready  = rdy & !stall & !flush & (SKID != 0 ? !sV : (!hV | dn.ready));
  assign accept    = up.valid & up.ready;
  assign fire      = hV & dn.ready & !stall & !flush;
  assign dn.valid  = hV;
  assign dn.data   = hV ? hData : '0;
  assign occupancy = {1'b0, hV} + {1'b0, sV};
  // with SKID=0, accepting into a full head implies fire, so the skid branch is unreachable
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy   <= 1'b0;
      hV    <= 1'b0;
      sV    <= 1'b0;
      hData <= '0;
      sData <= '0;
    end else if (flush) begin
      rdy   <= 1'b1;
      hV    <= 1'b0;
      sV    <= 1'b0;
      hData <= '0;
      sData <= '0;
    end else begin
      rdy <= 1'b1;
      if (fire && sV) begin
        hData <= sData;
        sV    <= 1'b0;
      end else if (accept && (fire || !hV)) begin
        hV    <= 1'b1;
        hData <= up.data;
      end else if (accept) begin
        sV    <= 1'b1;
        sData <= up.data;
      end else if (fire) begin
        hV <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bubble_cnt <= '0;
    else if (bubble_clr) bubble_cnt <= '0;
    else if (dn.ready && !hV && !stall && !flush && bubble_cnt != {CNT_W{1'b1}}) bubble_cnt <= bubble_cnt + 1'b1;
  end
endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Parametrised, handshaked successor to the fixed stall/flush inter-stage register between decode and execute.
- Carries an opaque payload of DATA_W bits: control bits, operands, immediate, PC, register indices, packed by the instantiating stage.
- Uses a valid/ready handshake with an optional second skid entry, so upstream ready can be fully registered.
- Keeps synchronous flush and stall, and adds an occupancy output and a saturating bubble counter for performance monitoring.

Parameters:
DATA_W, 32, payload width in bits (>=1)
SKID, 1, 0 = single-entry register with combinational ready path; 1 = two-entry skid buffer with registered in_ready
CNT_W, 16, bubble counter width (>=2)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
in_valid  input  1  upstream presents payload
in_ready  output  1  stage can accept payload this cycle
in_data  input  DATA_W  upstream payload
out_valid  output  1  stage holds a valid payload
out_ready  input  1  downstream consumes payload this cycle
out_data  output  DATA_W  payload of head entry; all zeros when out_valid=0
flush  input  1  synchronous kill of all held entries (hazard unit)
stall  input  1  synchronous freeze of all entries (hazard unit)
occupancy  output  2  number of valid entries: 0, 1 or 2
bubble_cnt  output  CNT_W  count of bubble cycles, saturating
bubble_clr  input  1  synchronous clear of bubble_cnt

Behaviour:
- Storage:
  - Head entry H (valid bit plus data) drives out_*.
  - Skid entry S exists only when SKID=1.
- Handshake events:
  - accept = in_valid & in_ready.
  - fire = out_valid & out_ready & !stall & !flush.
- Reset (rst=0, asynchronous):
  - H.v, S.v, H.data, S.data, bubble_cnt are all 0.
  - in_ready=0, out_valid=0, out_data=0, occupancy=0.
  - On the first edge after release, in_ready=1.
- Priority: reset > flush > stall > normal operation.
- flush=1:
  - On the next edge H.v, S.v and both data registers become 0; zero data is the NOP bubble.
  - in_ready=0 in the flush cycle, so no accept occurs.
  - bubble_cnt is not affected by flush.
- stall=1 (with flush=0):
  - All entries hold.
  - in_ready=0 and fire=0.
  - out_valid and out_data keep showing the held head.
- in_ready:
  - SKID=0: in_ready = !stall & !flush & (!H.v | out_ready). This is a combinational path from out_ready.
  - SKID=1: in_ready = !stall & !flush & !S.v. There is no path from out_ready.
- SKID=0 transitions:
  - EMPTY + accept -> FULL1 (H=in).
  - FULL1 + fire + accept -> FULL1 (H=in).
  - FULL1 + fire, no accept -> EMPTY.
- SKID=1 transitions (states EMPTY, ONE, TWO):
  - EMPTY + accept -> ONE, H=in_data.
  - ONE + accept + fire -> ONE, H=in_data.
  - ONE + accept, no fire -> TWO, S=in_data.
  - ONE + fire, no accept -> EMPTY.
  - TWO + fire -> ONE, H<=S (accept is impossible because in_ready=0).
  - TWO without fire holds.
- Ordering: payloads leave in acceptance order; no duplication, no loss except on flush.
- Data registers are written only on accept or shift; a drained head keeps stale data, but out_data is masked to 0.
- Latency and throughput:
  - First accept to out_valid is 1 cycle.
  - Sustained throughput is 1 payload/cycle with out_ready held high (both SKID values).
- occupancy = H.v + S.v, registered state.
- bubble_cnt:
  - Increments by 1 on each edge where out_ready=1, out_valid=0, stall=0 and flush=0.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - bubble_clr=1 forces 0 on the next edge, with priority over increment.

Test Plan:
1. Reset: assert rst=0 mid-stream with occupancy=2 -> out_valid=0, out_data=0, occupancy=0, bubble_cnt=0 immediately (asynchronous); in_ready=1 on the first edge after release.
2. Streaming, SKID=1, DATA_W=32: send 0x11, 0x22, 0x33 back-to-back with out_ready=1 -> out_data 0x11, 0x22, 0x33 on consecutive cycles, one cycle after each accept; occupancy stays 1.
3. Backpressure, SKID=1: hold out_ready=0 and offer 0xA, 0xB, 0xC -> 0xA and 0xB accepted, occupancy=2, in_ready=0, 0xC held upstream; raise out_ready -> output order 0xA, 0xB, 0xC with no loss.
4. Flush vs stall: with occupancy=2, assert flush=1 and stall=1 together -> next cycle occupancy=0, out_data=0; a stall alone with occupancy=1 and out_ready=1 holds the entry for its full duration.
5. SKID=0 pass-through: with H valid, out_ready=1 and in_valid=1 in the same cycle -> in_ready=1; the head is replaced by the new payload and occupancy stays 1.
6. Bubble counter, CNT_W=2: out_ready=1 with no input for 5 cycles -> bubble_cnt sequence 1, 2, 3, 3, 3; then bubble_clr=1 -> 0; flush does not alter the count.
